// File: rtl/cpu_trace_emitter.sv
// Serializes one CPU write-back event into an ASCII trace line, one byte per beat.
// Formats: "^<time>@<pc>: $<grf> <= <data>#" and "^<time>@<pc>: *<addr> <= <data>#".
//   state   | meaning
//   IDLE    | waiting for start
//   CARET   | '^'
//   TIME    | decimal time, no leading zeros
//   AT      | '@'
//   PC      | 8 hex digits of pc
//   COLON   | ':'
//   SP1     | ' '
//   MARK    | '$' register / '*' memory
//   OPER    | grf decimal or addr as 8 hex digits
//   SP2     | ' '
//   LT      | '<'
//   EQ      | '='
//   SP3     | ' '
//   DATA    | 8 hex digits of data
//   HASH    | '#', line terminator
module cpu_trace_emitter #(
   parameter int TIME_W   = 14,
   parameter int MAX_TIME = 9999
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              kind,
   input  logic [TIME_W-1:0] time_in,
   input  logic [31:0]       pc,
   input  logic [4:0]        grf,
   input  logic [31:0]       addr,
   input  logic [31:0]       data,
   output logic [7:0]        char,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [3:0] {
      S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_MARK,
      S_OPER, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        kind_q, kind_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [15:0] tdig_q, tdig_d;
   logic [1:0]  tlen_q, tlen_d;
   logic [7:0]  gdig_q, gdig_d;
   logic        glen_q, glen_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        beat;
   logic [31:0] t_ext;
   logic [31:0] g_ext;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   assign char_valid = (state_q != S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign err        = err_q;
   assign beat       = char_valid & char_ready;
   assign t_ext      = 32'(time_in);
   assign g_ext      = 32'(grf);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      data_d  = data_q;
      tdig_d  = tdig_q;
      tlen_d  = tlen_q;
      gdig_d  = gdig_q;
      glen_d  = glen_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      char    = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (t_ext > 32'(MAX_TIME)) begin
                  err_d = 1'b1;
               end else begin
                  kind_d  = kind;
                  pc_d    = pc;
                  addr_d  = addr;
                  data_d  = data;
                  // digits stored msd..lsd; length kept as (digit count - 1)
                  tdig_d  = {4'((t_ext / 1000) % 10), 4'((t_ext / 100) % 10),
                             4'((t_ext / 10) % 10), 4'(t_ext % 10)};
                  tlen_d  = (t_ext >= 1000) ? 2'd3 : (t_ext >= 100) ? 2'd2 :
                            (t_ext >= 10) ? 2'd1 : 2'd0;
                  gdig_d  = {4'(g_ext / 10), 4'(g_ext % 10)};
                  glen_d  = (g_ext >= 10);
                  state_d = S_CARET;
               end
            end
         end
         S_CARET: begin
            char = "^";
            if (beat) begin
               state_d = S_TIME;
               cnt_d   = {1'b0, tlen_q};
            end
         end
         S_TIME: begin
            char = hex_char(tdig_q[{cnt_q[1:0], 2'b00} +: 4]);
            if (beat) begin
               if (cnt_q == 3'd0) state_d = S_AT;
               else cnt_d = cnt_q - 3'd1;
            end
         end
         S_AT: begin
            char = "@";
            if (beat) begin
               state_d = S_PC;
               cnt_d   = 3'd7;
            end
         end
         S_PC: begin
            char = hex_char(pc_q[{cnt_q, 2'b00} +: 4]);
            if (beat) begin
               if (cnt_q == 3'd0) state_d = S_COLON;
               else cnt_d = cnt_q - 3'd1;
            end
         end
         S_COLON: begin
            char = ":";
            if (beat) state_d = S_SP1;
         end
         S_SP1: begin
            char = " ";
            if (beat) state_d = S_MARK;
         end
         S_MARK: begin
            char = kind_q ? "*" : "$";
            if (beat) begin
               state_d = S_OPER;
               cnt_d   = kind_q ? 3'd7 : {2'b00, glen_q};
            end
         end
         S_OPER: begin
            char = kind_q ? hex_char(addr_q[{cnt_q, 2'b00} +: 4])
                          : hex_char(gdig_q[{cnt_q[0], 2'b00} +: 4]);
            if (beat) begin
               if (cnt_q == 3'd0) state_d = S_SP2;
               else cnt_d = cnt_q - 3'd1;
            end
         end
         S_SP2: begin
            char = " ";
            if (beat) state_d = S_LT;
         end
         S_LT: begin
            char = "<";
            if (beat) state_d = S_EQ;
         end
         S_EQ: begin
            char = "=";
            if (beat) state_d = S_SP3;
         end
         S_SP3: begin
            char = " ";
            if (beat) begin
               state_d = S_DATA;
               cnt_d   = 3'd7;
            end
         end
         S_DATA: begin
            char = hex_char(data_q[{cnt_q, 2'b00} +: 4]);
            if (beat) begin
               if (cnt_q == 3'd0) state_d = S_HASH;
               else cnt_d = cnt_q - 3'd1;
            end
         end
         S_HASH: begin
            char = "#";
            if (beat) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         kind_q  <= 1'b0;
         pc_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         tdig_q  <= '0;
         tlen_q  <= '0;
         gdig_q  <= '0;
         glen_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tdig_q  <= tdig_d;
         tlen_q  <= tlen_d;
         gdig_q  <= gdig_d;
         glen_q  <= glen_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed table-driven bench for cpu_trace_emitter: whole trace lines are
// collected byte by byte and compared with hand-written expected strings.
module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        kind = 1'b0;
   logic [13:0] time_in = '0;
   logic [31:0] pc = '0;
   logic [4:0]  grf = '0;
   logic [31:0] addr = '0;
   logic [31:0] data = '0;
   logic [7:0]  ch;
   logic        char_valid;
   logic        char_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        kind;
      logic [13:0] t;
      logic [31:0] pc;
      logic [4:0]  grf;
      logic [31:0] addr;
      logic [31:0] data;
      bit          bp;
      string       exp;
   } vec_t;

   vec_t tab[6];

   cpu_trace_emitter #(.TIME_W(14), .MAX_TIME(9999)) dut (
      .clk(clk), .reset(reset), .start(start), .kind(kind), .time_in(time_in),
      .pc(pc), .grf(grf), .addr(addr), .data(data), .char(ch),
      .char_valid(char_valid), .char_ready(char_ready), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      kind    = v.kind;
      time_in = v.t;
      pc      = v.pc;
      grf     = v.grf;
      addr    = v.addr;
      data    = v.data;
   endtask

   // Runs one line; chained_in means start was already raised at the current negedge.
   task automatic run_line(input string nm, input vec_t v, input int poke_at,
                           input bit chained_in, input bit chain_out, input vec_t nxt);
      string      got;
      logic [7:0] prev;
      bit         stalled;
      bit         fin;
      int         cyc;
      if (!chained_in) begin
         @(negedge clk);
         drive(v);
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      check({nm, "_caret"}, {31'd0, char_valid, ch}, {31'd0, 1'b1, 8'h5e});
      got = "";
      prev = 8'h00;
      stalled = 1'b0;
      fin = 1'b0;
      cyc = 0;
      while (!fin && cyc < 400) begin
         char_ready = v.bp ? (cyc % 3 == 0) : 1'b1;
         if (stalled) check({nm, "_stable"}, {32'd0, ch}, {32'd0, prev});
         if (!char_valid) begin
            check({nm, "_valid_lost"}, {39'd0, char_valid}, 40'd1);
            fin = 1'b1;
         end else if (char_ready) begin
            got = {got, $sformatf("%c", ch)};
            stalled = 1'b0;
            if (ch == 8'h23) fin = 1'b1;
         end else begin
            stalled = 1'b1;
            prev = ch;
         end
         if (poke_at == cyc) begin
            start   = 1'b1;
            time_in = 14'd5;
            kind    = ~kind;
            grf     = 5'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      char_ready = 1'b1;
      check({nm, "_finished"}, {39'd0, fin}, 40'd1);
      check({nm, "_done"}, {37'd0, done, busy, char_valid}, {37'd0, 3'b100});
      check({nm, "_len"}, 40'(got.len()), 40'(v.exp.len()));
      checks++;
      if (got != v.exp) begin
         errors++;
         $display("FAIL %s_text actual \"%s\" expected \"%s\"", nm, got, v.exp);
      end
      if (chain_out) begin
         drive(nxt);
         start = 1'b1;
      end else begin
         @(negedge clk);
         check({nm, "_after"}, {37'd0, done, busy, char_valid}, 40'd0);
      end
   endtask

   initial begin
      vec_t dummy;
      tab[0] = '{1'b0, 14'd1024, 32'h000030fc, 5'd2, 32'h0, 32'h89abcdef, 1'b0,
                 "^1024@000030fc: $2 <= 89abcdef#"};
      tab[1] = '{1'b1, 14'd3338, 32'h00003130, 5'd0, 32'h0000f088, 32'hffffb528, 1'b0,
                 "^3338@00003130: *0000f088 <= ffffb528#"};
      tab[2] = '{1'b0, 14'd0, 32'h0, 5'd31, 32'h0, 32'hffffffff, 1'b0,
                 "^0@00000000: $31 <= ffffffff#"};
      tab[3] = '{1'b0, 14'd1024, 32'h000030fc, 5'd2, 32'h0, 32'h89abcdef, 1'b1,
                 "^1024@000030fc: $2 <= 89abcdef#"};
      tab[4] = '{1'b0, 14'd57, 32'hdeadbeef, 5'd10, 32'h0, 32'h0, 1'b0,
                 "^57@deadbeef: $10 <= 00000000#"};
      tab[5] = '{1'b1, 14'd9999, 32'h12345678, 5'd3, 32'habcdef01, 32'h1, 1'b1,
                 "^9999@12345678: *abcdef01 <= 00000001#"};
      dummy = tab[0];

      #2;
      check("reset_state", {32'd0, ch}, 40'd0);
      check("reset_flags", {36'd0, char_valid, busy, done, err}, 40'd0);
      @(negedge clk);
      reset = 1'b0;

      // line 1 feeds line 2 back to back in the done cycle; line 4 gets a stray start
      for (int i = 0; i < 6; i++) begin
         run_line($sformatf("line%0d", i), tab[i], (i == 4) ? 6 : -1,
                  i == 2, i == 1, (i < 5) ? tab[i + 1] : dummy);
      end

      @(negedge clk);
      drive(tab[0]);
      time_in = 14'd10000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("reject_pulse", {37'd0, err, busy, char_valid}, {37'd0, 3'b100});
      @(negedge clk);
      check("reject_after", {37'd0, err, busy, char_valid}, 40'd0);

      drive(tab[0]);
      char_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_reset_busy", {38'd0, busy, char_valid}, {38'd0, 2'b11});
      #1 reset = 1'b1;
      #1;
      check("mid_reset", {29'd0, ch, char_valid, busy, done}, 40'd0);
      @(negedge clk);
      reset = 1'b0;
      run_line("after_reset", tab[0], -1, 1'b0, 1'b0, dummy);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
